// File: rtl/pkt_flow_proc.sv
// -----------------------------------------------------------------------------
// pkt_flow_proc
//
// Store-and-forward packet flow processor. Checks sop/eop framing on the input
// beat stream, buffers each packet in an internal FIFO and replays it only once
// the whole packet has been received. Malformed packets and packets that
// overflow the buffer are discarded. Every terminated input packet produces one
// feedback pulse for upstream flow control.
//
// Ports:
//   clk           - single clock, rising edge
//   rst_n         - asynchronous reset, ACTIVE-HIGH despite the name
//   data_in_vld   - input beat valid
//   sop_in_vld    - first beat of packet (qualified by data_in_vld)
//   eop_in_vld    - last beat of packet (qualified by data_in_vld)
//   data_in       - input beat data
//   data_out_vld  - output beat valid (no backpressure)
//   sop_out_vld   - first output beat of packet
//   eop_out_vld   - last output beat of packet
//   data_out      - output beat data
//   fb_vld        - one-cycle pulse: an input packet has terminated
//   fb_eop        - with fb_vld: 1 = committed, 0 = dropped
//   fb_cnt        - parity of the committed packet count
// -----------------------------------------------------------------------------
module pkt_flow_proc #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_in_vld,
    input  logic                  sop_in_vld,
    input  logic                  eop_in_vld,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_out_vld,
    output logic                  sop_out_vld,
    output logic                  eop_out_vld,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fb_vld,
    output logic                  fb_eop,
    output logic                  fb_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;              // entry = {sop, eop, data}
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_OCC = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IN_PKT,
        S_DROP
    } state_t;

    state_t state_q, state_d;

    // Pointers carry one extra wrap bit so full/empty are distinguishable.
    logic [AW:0] wr_ptr_q,  wr_ptr_d;    // speculative write pointer
    logic [AW:0] cwr_ptr_q, cwr_ptr_d;   // committed write pointer = start of open packet
    logic [AW:0] rd_ptr_q,  rd_ptr_d;
    logic [AW:0] pkt_cnt_q, pkt_cnt_d;   // committed packets not yet fully read
    logic        rd_busy_q, rd_busy_d;   // read side is in the middle of a packet

    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic                  dout_vld_q;
    logic                  dout_sop_q;
    logic                  dout_eop_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  fb_vld_q;
    logic                  fb_eop_q;
    logic                  fb_cnt_q;

    logic          wr_en;
    logic          commit;
    logic          drop;
    logic          full;
    logic          rd_en;
    logic          rd_eop;
    logic [EW-1:0] rd_entry;

    // Occupancy counts uncommitted beats too, and uses only registered
    // pointers, so a read in the same cycle never frees room for a write.
    assign full = ((wr_ptr_q - rd_ptr_q) == DEPTH_OCC);

    // ------------------------------------------------------------------
    // Input framer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cwr_ptr_d = cwr_ptr_q;
        wr_en     = 1'b0;
        commit    = 1'b0;
        drop      = 1'b0;

        if (data_in_vld) begin
            case (state_q)
                S_IDLE: begin
                    // Beats without sop are stray and silently ignored.
                    if (sop_in_vld) begin
                        if (full) begin
                            if (eop_in_vld) begin
                                drop = 1'b1;
                            end else begin
                                state_d = S_DROP;
                            end
                        end else begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            if (eop_in_vld) begin
                                commit    = 1'b1;
                                cwr_ptr_d = wr_ptr_q + PTR_ONE;
                            end else begin
                                state_d = S_IN_PKT;
                            end
                        end
                    end
                end

                S_IN_PKT: begin
                    if (sop_in_vld || full) begin
                        // Framing error or overflow: rewind to the packet start,
                        // which is always the committed write pointer.
                        wr_ptr_d = cwr_ptr_q;
                        if (eop_in_vld) begin
                            drop    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (eop_in_vld) begin
                            commit    = 1'b1;
                            cwr_ptr_d = wr_ptr_q + PTR_ONE;
                            state_d   = S_IDLE;
                        end
                    end
                end

                S_DROP: begin
                    if (eop_in_vld) begin
                        drop    = 1'b1;
                        state_d = S_IDLE;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    always_comb begin
        rd_entry  = mem_q[rd_ptr_q[AW-1:0]];
        // Only committed packets are ever started, and a started packet is
        // fully committed, so the reader never touches uncommitted beats.
        rd_en     = rd_busy_q || (pkt_cnt_q != '0);
        rd_eop    = rd_en && rd_entry[EW-2];
        rd_ptr_d  = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        rd_busy_d = rd_en ? !rd_entry[EW-2] : rd_busy_q;

        pkt_cnt_d = pkt_cnt_q;
        case ({commit, rd_eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            cwr_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            rd_busy_q  <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            dout_q     <= '0;
            fb_vld_q   <= 1'b0;
            fb_eop_q   <= 1'b0;
            fb_cnt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cwr_ptr_q  <= cwr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            rd_busy_q  <= rd_busy_d;
            dout_vld_q <= rd_en;
            dout_sop_q <= rd_en && rd_entry[EW-1];
            dout_eop_q <= rd_eop;
            if (rd_en) begin
                dout_q <= rd_entry[DATA_WIDTH-1:0];
            end
            fb_vld_q   <= commit || drop;
            fb_eop_q   <= commit;
            fb_cnt_q   <= fb_cnt_q ^ commit;
        end
    end

    // Buffer storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {sop_in_vld, eop_in_vld, data_in};
        end
    end

    assign data_out_vld = dout_vld_q;
    assign sop_out_vld  = dout_sop_q;
    assign eop_out_vld  = dout_eop_q;
    assign data_out     = dout_q;
    assign fb_vld       = fb_vld_q;
    assign fb_eop       = fb_eop_q;
    assign fb_cnt       = fb_cnt_q;

endmodule

// File: tb/tb_pkt_flow_proc.sv
// -----------------------------------------------------------------------------
// tb_pkt_flow_proc
//
// Self-checking bench for pkt_flow_proc. A table of input beats carries the
// expected feedback per beat and whether the beat must reappear on the output;
// surviving beats are queued and matched in order by an output monitor.
// -----------------------------------------------------------------------------
module tb_pkt_flow_proc;

    logic       clk;
    logic       rst_n;
    logic       data_in_vld;
    logic       sop_in_vld;
    logic       eop_in_vld;
    logic [7:0] data_in;
    logic       data_out_vld;
    logic       sop_out_vld;
    logic       eop_out_vld;
    logic [7:0] data_out;
    logic       fb_vld;
    logic       fb_eop;
    logic       fb_cnt;

    pkt_flow_proc #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in_vld (data_in_vld),
        .sop_in_vld  (sop_in_vld),
        .eop_in_vld  (eop_in_vld),
        .data_in     (data_in),
        .data_out_vld(data_out_vld),
        .sop_out_vld (sop_out_vld),
        .eop_out_vld (eop_out_vld),
        .data_out    (data_out),
        .fb_vld      (fb_vld),
        .fb_eop      (fb_eop),
        .fb_cnt      (fb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       sop;
        logic       eop;
        logic [7:0] data;
        logic       keep;    // beat must appear on the output
        logic       fb;      // fb_vld expected after this beat
        logic       fb_ok;   // expected fb_eop when fb is set
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];    // {sop, eop, data}
    int         checks = 0;
    int         errors = 0;
    logic       exp_cnt = 1'b0;
    int         run_len = 0;
    int         max_run = 0;
    logic       mon_in_pkt = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic s, input logic e, input logic [7:0] d,
                       input logic keep, input logic fb, input logic fb_ok);
        vec_t r;
        r.vld = v; r.sop = s; r.eop = e; r.data = d;
        r.keep = keep; r.fb = fb; r.fb_ok = fb_ok;
        vecs.push_back(r);
    endtask

    // Applies one beat for one clock and checks the feedback it produces.
    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d,
                         input logic keep, input logic fb, input logic fb_ok);
        data_in_vld = v;
        sop_in_vld  = s;
        eop_in_vld  = e;
        data_in     = d;
        if (keep) exp_q.push_back({s, e, d});
        @(posedge clk);
        #1;
        data_in_vld = 1'b0;
        sop_in_vld  = 1'b0;
        eop_in_vld  = 1'b0;
        if (fb && fb_ok) exp_cnt = ~exp_cnt;
        check("fb_vld", 16'(fb_vld), 16'(fb));
        if (fb) check("fb_eop", 16'(fb_eop), 16'(fb_ok));
        check("fb_cnt", 16'(fb_cnt), 16'(exp_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Output monitor: in-order scoreboard plus gap detection within a packet.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_in_pkt = 1'b0;
            run_len    = 0;
        end else if (data_out_vld) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none",
                         {sop_out_vld, eop_out_vld, data_out});
            end else begin
                check("out_beat", 16'({sop_out_vld, eop_out_vld, data_out}), 16'(exp_q.pop_front()));
            end
            if (sop_out_vld) mon_in_pkt = 1'b1;
            if (eop_out_vld) mon_in_pkt = 1'b0;
        end else begin
            run_len = 0;
            if (mon_in_pkt) begin
                checks++;
                errors++;
                $display("FAIL out_gap: got data_out_vld 0 expected 1 inside packet");
                mon_in_pkt = 1'b0;
            end
        end
    end

    initial begin
        // Stimulus table
        add(1, 1, 1, 8'hA5, 1, 1, 1);                  // single-beat packet
        for (int i = 0; i < 3; i++) add(0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 8'h55, 0, 0, 0);                  // stray beats in IDLE
        add(1, 0, 1, 8'h66, 0, 0, 0);
        add(0, 1, 1, 8'h77, 0, 0, 0);                  // ignored: vld low
        add(1, 1, 0, 8'h01, 0, 0, 0);                  // sop inside packet
        add(1, 0, 0, 8'h02, 0, 0, 0);
        add(1, 1, 0, 8'h03, 0, 0, 0);
        add(1, 0, 1, 8'h04, 0, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 0, 8'h31, 0, 0, 0);                  // sop+eop inside packet
        add(1, 1, 1, 8'h32, 0, 1, 0);
        for (int i = 0; i < 20; i++)                   // overflow: 20 > 16
            add(1, i == 0, i == 19, 8'(8'h80 + i), 0, i == 19, 0);
        add(1, 1, 0, 8'hC1, 1, 0, 0);                  // survives after overflow
        add(1, 0, 0, 8'hC2, 1, 0, 0);
        add(1, 0, 1, 8'hC3, 1, 1, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++)                   // exactly fills the FIFO
            add(1, i == 0, i == 15, 8'(8'h40 + i), 1, i == 15, 1);

        data_in_vld = 1'b0;
        sop_in_vld  = 1'b0;
        eop_in_vld  = 1'b0;
        data_in     = 8'h00;
        rst_n       = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out_vld", 16'(data_out_vld), 16'd0);
        check("rst_sop_out_vld",  16'(sop_out_vld),  16'd0);
        check("rst_eop_out_vld",  16'(eop_out_vld),  16'd0);
        check("rst_data_out",     16'(data_out),     16'd0);
        check("rst_fb_vld",       16'(fb_vld),       16'd0);
        check("rst_fb_eop",       16'(fb_eop),       16'd0);
        check("rst_fb_cnt",       16'(fb_cnt),       16'd0);
        rst_n = 1'b0;

        // 4-beat packet with output latency check
        drive(1, 1, 0, 8'h11, 1, 0, 0);
        drive(1, 0, 0, 8'h22, 1, 0, 0);
        drive(1, 0, 0, 8'h33, 1, 0, 0);
        drive(1, 0, 1, 8'h44, 1, 1, 1);
        check("lat_vld_eop_cycle", 16'(data_out_vld), 16'd0);
        @(posedge clk);
        #1;
        check("lat_vld_first", 16'(data_out_vld), 16'd1);
        check("lat_sop_first", 16'(sop_out_vld),  16'd1);
        check("lat_data_first", 16'(data_out),    16'h11);
        idle(6);

        // Table-driven vectors
        foreach (vecs[i])
            drive(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].data,
                  vecs[i].keep, vecs[i].fb, vecs[i].fb_ok);
        idle(20);

        // Three 5-beat packets back to back -> 15 contiguous output beats
        max_run = 0;
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 5; b++)
                drive(1, b == 0, b == 4, 8'(8'hB0 + 8'(p * 16) + 8'(b)), 1, b == 4, 1);
        idle(12);
        check("b2b_run_len", 16'(max_run), 16'd15);

        // Reset while a packet is streaming out
        drive(1, 1, 0, 8'hD1, 1, 0, 0);
        drive(1, 0, 0, 8'hD2, 1, 0, 0);
        drive(1, 0, 0, 8'hD3, 1, 0, 0);
        drive(1, 0, 1, 8'hD4, 1, 1, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_vld", 16'(data_out_vld), 16'd1);
        rst_n = 1'b1;
        #1;
        check("async_rst_vld",    16'(data_out_vld), 16'd0);
        check("async_rst_sop",    16'(sop_out_vld),  16'd0);
        check("async_rst_data",   16'(data_out),     16'd0);
        check("async_rst_fb_cnt", 16'(fb_cnt),       16'd0);
        exp_q.delete();
        exp_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1, 1, 0, 8'hE1, 1, 0, 0);
        drive(1, 0, 1, 8'hE2, 1, 1, 1);
        idle(6);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_flow_proc.md
# pkt_flow_proc

Store-and-forward packet flow processor sitting between the packet source interface and the packet sink interface. It checks sop/eop framing on an 8-bit beat stream, buffers each packet in an internal FIFO, and replays it only once the whole packet has been received. It discards packets that are malformed or that overflow the buffer. For every terminated input packet it reports one feedback pulse to upstream flow control.

## Interface
- DATA_WIDTH, 8, width of data_in/data_out.
- FIFO_DEPTH, 16, buffer entries (power of two, ≥2); each entry holds {sop, eop, data}.

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-high despite the name; asserting it clears all state immediately.
- data_in_vld  input  1  input beat valid.
- sop_in_vld  input  1  first beat of packet; qualified by data_in_vld.
- eop_in_vld  input  1  last beat of packet; qualified by data_in_vld.
- data_in  input  DATA_WIDTH  input beat data.
- data_out_vld  output  1  output beat valid; no backpressure.
- sop_out_vld  output  1  first output beat of packet.
- eop_out_vld  output  1  last output beat of packet.
- data_out  output  DATA_WIDTH  output beat data.
- fb_vld  output  1  one-cycle pulse: an input packet has terminated.
- fb_eop  output  1  valid with fb_vld: 1 = packet committed, 0 = packet dropped.
- fb_cnt  output  1  toggles on every committed packet; parity of committed packet count.

## Operation
- sop_in_vld, eop_in_vld and data_in are ignored while data_in_vld = 0.
- The input framer has three states: IDLE, IN_PKT and DROP.
- IDLE:
  - vld & sop & eop: single-beat packet; written and committed in the same cycle.
  - vld & sop & !eop: write the beat, record the packet start pointer, go to IN_PKT.
  - vld & !sop: stray beat; discarded with no feedback.
- IN_PKT:
  - vld & !sop: write the beat.
  - vld & eop: write the beat, commit the packet, go to IDLE.
  - vld & sop: framing error. Drop the current packet, which rewinds the write pointer to its start. The new sop beat is discarded too. Go to DROP (or to IDLE with a drop pulse if that beat also has eop).
- DROP: discard all beats up to and including the next eop. At the eop, pulse fb_vld with fb_eop = 0 and go to IDLE.
- Overflow: a beat to be written while the FIFO is full (occupancy includes uncommitted beats) drops the packet. The write pointer rewinds, the beat is discarded, and the framer goes to DROP, or to IDLE with a drop pulse if that beat carries eop. A packet longer than FIFO_DEPTH is always dropped.
- Commit: increment the committed-packet count and the committed write pointer. Pulse fb_vld = 1, fb_eop = 1, and toggle fb_cnt.
- Read side:
  - When the read side is idle and the committed count is > 0, it streams one packet, one beat per cycle, with no gaps.
  - When it reads an eop, it decrements the count and may start the next committed packet on the very next cycle.
  - It never reads uncommitted beats.

## Timing
- All outputs are registered.
- Reset values: data_out_vld, sop_out_vld, eop_out_vld, fb_vld, fb_eop and fb_cnt are 0; data_out is 0. FIFO is empty, counts are 0, framer is IDLE.
- An eop beat sampled at edge k is committed at edge k. fb_vld/fb_eop are high during cycle k→k+1.
- The first beat of that packet appears on the outputs after edge k+1. An L-beat packet occupies L consecutive output cycles.
- Full is evaluated from occupancy registered before the edge. A read in the same cycle does not free space for a write in that cycle.
- A simultaneous commit and read-eop leaves the count unchanged.
- Reset asserted mid-packet discards all buffered and in-flight data. Outputs go to their reset values asynchronously.

## Test plan
- After reset, a 4-beat packet 0x11,0x22,0x33,0x44 (sop on the first beat, eop on the last) → the same 4 beats on the outputs starting 1 cycle after the eop cycle, with sop/eop on beats 1/4. fb_vld=1, fb_eop=1, fb_cnt 0→1.
- Single beat 0xA5 with sop=eop=1 → one output beat 0xA5 with sop=eop=1. fb_cnt toggles.
- Beats with vld=1, sop=0 while IDLE → no output and no fb_vld.
- Packet 0x01,0x02 followed by sop 0x03 mid-packet, then eop 0x04 → nothing output. One fb_vld pulse with fb_eop=0 at the eop; fb_cnt unchanged.
- 20-beat packet with FIFO_DEPTH=16 → dropped, fb_eop=0. A following 3-beat packet passes intact.
- Three 5-beat packets back to back → 15 contiguous output beats, three fb_vld/fb_eop=1 pulses, fb_cnt ends at 1.
